// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO built on an internal circular
// buffer. Pointer management, occupancy counting, full/empty, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//
// Ports:
//   clk          single clock, all state updates on posedge
//   rst          synchronous, active-high reset
//   wr_enb       write request, data_in captured when accepted
//   rd_enb       read request
//   data_in      write data (DATA_WIDTH)
//   data_out     registered read data (DATA_WIDTH)
//   valid_out    data_out was loaded by an accepted read on the last edge
//   full/empty   count == DEPTH / count == 0
//   almost_full  count >= AF_THRESH
//   almost_empty count <= AE_THRESH
//   overflow     sticky: a write was rejected
//   underflow    sticky: a read was rejected
//   count        current occupancy, 0..DEPTH (ADDR_SIZE+1 bits)
//
// Handshake: wr_enb/rd_enb are requests sampled on posedge. A read is
// accepted when the FIFO is not empty. A write is accepted when the FIFO is
// not full, or when it is full and a read is accepted on the same edge.
// full/empty play the role of "ready" and are registered-state decodes, so
// a producer/consumer may look at them before raising a request. Rejected
// requests are dropped and latched in overflow/underflow.
module fifo_param #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_SIZE  = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_enb,
    input  logic                  rd_enb,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_SIZE:0]    count
);

    localparam int DEPTH = 2 ** ADDR_SIZE;

    // Constants sized to the full count width so that count == DEPTH is
    // compared without truncation.
    localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE + 1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE + 1)'(AF_THRESH);
    localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0]  wr_ptr;
    logic [ADDR_SIZE-1:0]  rd_ptr;
    logic                  rd_ok;
    logic                  wr_ok;

    // A write to a full FIFO is legal when a read frees the slot on the same
    // edge; the read takes the old word before the write overwrites it.
    assign rd_ok = rd_enb && !empty;
    assign wr_ok = wr_enb && (!full || rd_ok);

    // Flags decode the registered count only, so no input reaches an output
    // combinationally.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Storage is deliberately not reset; stale words are unreachable because
    // the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            valid_out <= rd_ok;

            if (wr_ok) begin
                // DEPTH is a power of two, so natural pointer overflow wraps
                // DEPTH-1 back to 0.
                wr_ptr <= wr_ptr + ADDR_SIZE'(1);
            end

            if (rd_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_SIZE'(1);
            end

            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (wr_enb && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (rd_enb && !rd_ok) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed self-checking bench for fifo_param with default
// parameters (DATA_WIDTH=10, DEPTH=8, AF_THRESH=6, AE_THRESH=2). Expected
// values are hand-computed constants per scenario.
module tb_fifo_param;

    logic       clk;
    logic       rst;
    logic       wr_enb;
    logic       rd_enb;
    logic [9:0] data_in;
    logic [9:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;
    logic [3:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    fifo_param #(
        .DATA_WIDTH(10),
        .ADDR_SIZE (3),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_enb      (wr_enb),
        .rd_enb      (rd_enb),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow),
        .count       (count)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Driver: apply requests for one edge, then sample 1 time unit after it.
    task automatic step(input logic w, input logic r, input logic [9:0] d);
        wr_enb  = w;
        rd_enb  = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr_enb  = 1'b0;
        rd_enb  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, '0);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        wr_enb  = 1'b0;
        rd_enb  = 1'b0;
        data_in = '0;

        // 1. Reset then idle
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        rst = 1'b0;
        step(1'b0, 1'b0, '0);
        check("rst_empty", empty, 1);
        check("rst_ae", almost_empty, 1);
        check("rst_count", count, 0);
        check("rst_dout", data_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);

        // 2. Fill and overflow
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 10'(i));
            check("fill_count", count, i);
            check("fill_af", almost_full, (i >= 6) ? 1 : 0);
            check("fill_ae", almost_empty, (i <= 2) ? 1 : 0);
            check("fill_full", full, (i == 8) ? 1 : 0);
            check("fill_valid", valid_out, 0);
        end
        step(1'b1, 1'b0, 10'h0FF);
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 8);
        check("ovf_full", full, 1);
        step(1'b0, 1'b0, '0);
        check("ovf_sticky", overflow, 1);

        // 3. Drain and underflow
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, '0);
            check("drain_data", data_out, i);
            check("drain_valid", valid_out, 1);
            check("drain_count", count, 8 - i);
        end
        check("drain_empty", empty, 1);
        step(1'b0, 1'b1, '0);
        check("udf_valid", valid_out, 0);
        check("udf_flag", underflow, 1);
        check("udf_hold", data_out, 10'h008);
        check("udf_count", count, 0);

        // 4. Wrap-around
        do_reset();
        check("wrap_rst_ovf", overflow, 0);
        check("wrap_rst_udf", underflow, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 10'(32'h0A0 + i));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, '0);
            check("wrap_pre_data", data_out, 32'h0A0 + i);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'(32'h100 + i));
        check("wrap_full", full, 1);
        check("wrap_count", count, 8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, '0);
            check("wrap_data", data_out, 32'h100 + i);
            check("wrap_valid", valid_out, 1);
        end
        check("wrap_empty", empty, 1);
        step(1'b0, 1'b0, '0);
        check("idle_valid", valid_out, 0);
        check("idle_hold", data_out, 10'h107);

        // 5. Simultaneous access
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 10'(i));
        step(1'b1, 1'b1, 10'h3CC);
        check("rw_full_data", data_out, 10'h001);
        check("rw_full_valid", valid_out, 1);
        check("rw_full_count", count, 8);
        check("rw_full_ovf", overflow, 0);
        for (int i = 2; i <= 8; i++) begin
            step(1'b0, 1'b1, '0);
            check("rw_tail_data", data_out, i);
        end
        step(1'b0, 1'b1, '0);
        check("rw_3cc", data_out, 10'h3CC);
        check("rw_drained", empty, 1);
        step(1'b1, 1'b1, 10'h2AA);
        check("rw_empty_count", count, 1);
        check("rw_empty_valid", valid_out, 0);
        check("rw_empty_udf", underflow, 1);
        check("rw_empty_hold", data_out, 10'h3CC);
        step(1'b0, 1'b1, '0);
        check("rw_2aa", data_out, 10'h2AA);

        // 6. Reset mid-operation (underflow is still set from above)
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 10'(32'h050 + i));
        check("mid_pre_count", count, 4);
        check("mid_pre_udf", underflow, 1);
        rst = 1'b1;
        step(1'b1, 1'b0, 10'h3FF);
        rst = 1'b0;
        check("mid_count", count, 0);
        check("mid_empty", empty, 1);
        check("mid_udf", underflow, 0);
        check("mid_ovf", overflow, 0);
        check("mid_valid", valid_out, 0);
        step(1'b1, 1'b0, 10'h155);
        check("mid_wr_count", count, 1);
        step(1'b0, 1'b1, '0);
        check("mid_rd_data", data_out, 10'h155);
        check("mid_rd_valid", valid_out, 1);
        check("mid_rd_empty", empty, 1);

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO. It is the next generation of the team's simple dual-address RAM. An internal circular-buffer memory is wrapped with pointer management, occupancy counting, full/empty and programmable almost-full/almost-empty flags, and sticky error flags. It sits in the PCIe datapath as the elastic buffer between the transaction and data-link stages. Users no longer drive read or write addresses.

Parameters:
DATA_WIDTH, 10, width of each stored word.
ADDR_SIZE, 3, pointer width; DEPTH = 2**ADDR_SIZE (default 8 entries).
AF_THRESH, 6, almost_full asserted when count >= AF_THRESH (legal range 1..DEPTH).
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (legal range 0..DEPTH-1).

Ports:
clk  input  1  single clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
wr_enb  input  1  write request.
rd_enb  input  1  read request.
data_in  input  DATA_WIDTH  write data.
data_out  output  DATA_WIDTH  registered read data.
valid_out  output  1  data_out updated by an accepted read on the last edge.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_THRESH.
almost_empty  output  1  count <= AE_THRESH.
overflow  output  1  sticky: a write was rejected.
underflow  output  1  sticky: a read was rejected.
count  output  ADDR_SIZE+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset: rst high at a posedge sets the following; memory contents are not cleared.
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, valid_out=0.
  - overflow=0, underflow=0.
  - Derived flags: empty=1, full=0, almost_empty=1, almost_full=0.
- Reset priority: rst overrides wr_enb/rd_enb in the same cycle. Reset mid-operation discards all stored data; the next write lands at address 0.
- Read acceptance: rd_ok = rd_enb && !empty.
- Write acceptance: wr_ok = wr_enb && (!full || rd_ok). A write while full is accepted only if a read frees a slot in the same cycle.
- Accepted write: mem[wr_ptr] <= data_in; wr_ptr increments, wrapping from DEPTH-1 to 0.
- Accepted read: data_out <= mem[rd_ptr]; rd_ptr increments with the same wrap; valid_out=1 for exactly the following cycle.
- Idle read: with no accepted read, valid_out=0 and data_out holds its previous value.
- Read latency: one clock from the rd_enb sampling edge to data_out/valid_out.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- Flags: full/empty/almost_* are combinational decodes of the count register, so they reflect the state after the last edge.
- Simultaneous read and write when full (wr_ptr == rd_ptr): read-before-write. data_out receives the old word and the new word overwrites the slot. count stays DEPTH.
- Simultaneous read and write when empty: the read is rejected and underflow is set. The write is accepted; count becomes 1. There is no write-to-read bypass, so valid_out=0.
- Rejected write (wr_enb && full && !rd_ok): data is dropped and overflow=1.
- Rejected read (rd_enb && empty): pointers unchanged; underflow=1 and valid_out=0.
- overflow/underflow stay high until rst.
- No combinational path from inputs to any output.
- Thresholds are compared against the full ADDR_SIZE+1-bit count; there is no truncation at count == DEPTH.

Test Plan:
1. Reset then idle. Hold rst=1 for 2 cycles, then release. Expect empty=1, almost_empty=1, count=0, data_out=0, valid_out=0, all other flags 0.
2. Fill and overflow. Write 'h001..'h008 on consecutive cycles.
   - almost_full rises after the 6th write; almost_empty falls after the 3rd; full=1 and count=8 after the 8th.
   - A 9th write of 'h0FF sets overflow=1; count stays 8.
3. Drain and underflow. Read 8 times.
   - data_out = 'h001..'h008 in order, valid_out high each cycle after the read, empty=1 at the end.
   - A 9th read leaves valid_out=0 and sets underflow=1.
4. Wrap-around. After reset, write/read 5 words (0x0A0..0x0A4), then write 8 words 'h100..'h107 and read 8. Output order must be 'h100..'h107 with the pointers wrapped; full=1 after the 8 writes.
5. Simultaneous access.
   - Full FIFO holding 'h001..'h008, rd_enb=wr_enb=1 with data_in='h3CC: data_out='h001, count stays 8, and 'h3CC is read out as the 8th word after the remaining 7.
   - Empty FIFO, both asserted with 'h2AA: count=1, valid_out=0, underflow=1.
6. Reset mid-operation. Write 4 words, assert rst for 1 cycle alongside wr_enb=1. Expect count=0, empty=1, and sticky flags cleared. Then write 'h155 and read it: data_out='h155 one cycle later.
